// File: rtl/fbosc_checker_if.sv
// Status/stimulus bundle between an oscillator-pair source and its checker.
// CNT_W must match the CNT_W of the checker instance it connects to.
interface fbosc_checker_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             a;
  logic             b;
  logic             clr_err;
  logic             locked;
  logic             fault;
  logic [CNT_W-1:0] tog_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, a, b, clr_err,
    input  locked, fault, tog_cnt, err_cnt
  );

  modport slave (
    input  en, a, b, clr_err,
    output locked, fault, tog_cnt, err_cnt
  );
endinterface

// File: rtl/fbosc_checker.sv
// Monitors a complementary toggling pair (a, b): acquires lock, tracks, counts toggles/errors, sticky fault.
// Status is registered one edge after the sample that causes it; no flow control, one sample per clk.
module fbosc_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int FAULT_LIMIT = 2,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  fbosc_checker_if.slave  bus
);

  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int BW = (FAULT_LIMIT > 1) ? $clog2(FAULT_LIMIT) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(FAULT_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             have_prev;
  logic             a_p;
  logic [GW-1:0]    good_run, good_run_n;
  logic [BW-1:0]    bad_run, bad_run_n;
  logic [CNT_W-1:0] tog_cnt, tog_cnt_n;
  logic [CNT_W-1:0] err_cnt, err_cnt_n;
  logic             good;
  logic             bad;

  // Without a previous sample there is nothing to compare against: neutral.
  assign good = have_prev && (bus.a != bus.b) && (bus.a != a_p);
  assign bad  = have_prev && !good;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      have_prev <= 1'b0;
      a_p       <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
      tog_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      good_run  <= good_run_n;
      bad_run   <= bad_run_n;
      tog_cnt   <= tog_cnt_n;
      err_cnt   <= err_cnt_n;
      have_prev <= bus.en;
      if (bus.en) begin
        a_p <= bus.a;
      end
    end
  end

  always_comb begin
    state_n    = state;
    good_run_n = good_run;
    bad_run_n  = bad_run;
    tog_cnt_n  = tog_cnt;
    err_cnt_n  = err_cnt;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_n = ACQ;
        end
      end
      ACQ: begin
        if (!bus.en) begin
          state_n = IDLE;
        end else if (good) begin
          if (good_run == GOOD_LAST) begin
            state_n    = TRACK;
            good_run_n = '0;
          end else begin
            good_run_n = good_run + 1'b1;
          end
        end else if (bad) begin
          good_run_n = '0;
        end
      end
      TRACK: begin
        if (!bus.en) begin
          state_n = IDLE;
        end else if (good) begin
          bad_run_n = '0;
          tog_cnt_n = tog_cnt + 1'b1;
        end else if (bad) begin
          if (err_cnt != {CNT_W{1'b1}}) begin
            err_cnt_n = err_cnt + 1'b1;
          end
          if (bad_run == BAD_LAST) begin
            state_n   = FAULT;
            bad_run_n = '0;
          end else begin
            bad_run_n = bad_run + 1'b1;
          end
        end
      end
      FAULT: begin
        if (bus.clr_err) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) begin
      good_run_n = '0;
      bad_run_n  = '0;
    end
    // Clear beats a coincident error increment.
    if (bus.clr_err) begin
      err_cnt_n = '0;
    end
  end

  always_comb begin
    bus.locked = (state == TRACK);
    bus.fault  = (state == FAULT);
  end

  assign bus.tog_cnt = tog_cnt;
  assign bus.err_cnt = err_cnt;

endmodule
